// File: rtl/ddr_burst_arbiter_pkg.sv
// Shared state encodings, grant identifiers and default widths for the DDR burst arbiter.
package ddr_burst_arbiter_pkg;

    localparam int DEF_DDR_ADDR_WIDTH = 28;
    localparam int DEF_ISA_WIDTH      = 30;
    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_DDR_DATA_WIDTH = 64;
    localparam int DEF_LEN_WIDTH      = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISA_RD = 3'd1,
        ST_DAT_RD = 3'd2,
        ST_DAT_WR = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_t;

    typedef enum logic {
        GRANT_ISA  = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

endpackage

// File: rtl/ddr_burst_arbiter_beat_counter.sv
// Beat counter reused by every grant: cleared at grant, counts accepted beats and
// flags the beat that completes the latched burst length.
module ddr_burst_arbiter_beat_counter
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_LEN_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] len,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign last = en && (count == len - WIDTH'(1));

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter sharing one DDR burst port between the instruction cache (reads)
// and the data cache (reads and writes); one captured request becomes one DDR burst.
module ddr_burst_arbiter
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH,
    parameter int ISA_WIDTH      = DEF_ISA_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int DDR_DATA_WIDTH = DEF_DDR_DATA_WIDTH,
    parameter int LEN_WIDTH      = DEF_LEN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      isa_rd_req,
    input  logic [DDR_ADDR_WIDTH-1:0] isa_rd_addr,
    input  logic [LEN_WIDTH-1:0]      isa_rd_len,
    output logic [ISA_WIDTH-1:0]      isa_rd_data,
    output logic                      isa_rd_valid,
    output logic [LEN_WIDTH-1:0]      isa_rd_cnt,
    output logic                      isa_done,
    input  logic                      dat_rd_req,
    input  logic                      dat_wr_req,
    input  logic [DDR_ADDR_WIDTH-1:0] dat_addr,
    input  logic [LEN_WIDTH-1:0]      dat_len,
    input  logic [DATA_WIDTH-1:0]     dat_wr_data,
    output logic                      dat_wr_data_req,
    output logic [DATA_WIDTH-1:0]     dat_rd_data,
    output logic                      dat_rd_valid,
    output logic [LEN_WIDTH-1:0]      dat_rd_cnt,
    output logic                      dat_done,
    output logic                      rd_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    output logic [LEN_WIDTH-1:0]      rd_burst_len,
    input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
    input  logic                      rd_burst_data_valid,
    input  logic                      rd_burst_finish,
    output logic                      wr_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
    output logic [LEN_WIDTH-1:0]      wr_burst_len,
    output logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
    input  logic                      wr_burst_data_req,
    input  logic                      wr_burst_finish,
    output logic [2:0]                grant_state
);

    // Handshake: a requester holds *_req until its one-cycle *_done; DDR side holds
    // *_burst_req until the first beat (data_valid / wr_burst_data_req) is seen.
    arb_state_t state_q, state_d;
    grant_t     last_grant_q, last_grant_d;
    logic       cur_isa_q, cur_isa_d;
    logic       started_q, started_d;
    logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;

    logic                      rd_burst_req_d, wr_burst_req_d;
    logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr_d, wr_burst_addr_d;
    logic [LEN_WIDTH-1:0]      rd_burst_len_d, wr_burst_len_d;
    logic [ISA_WIDTH-1:0]      isa_rd_data_d;
    logic [DATA_WIDTH-1:0]     dat_rd_data_d;
    logic                      isa_rd_valid_d, dat_rd_valid_d, isa_done_d, dat_done_d;
    logic [LEN_WIDTH-1:0]      isa_rd_cnt_d, dat_rd_cnt_d;

    logic                 cnt_clear, cnt_en, cnt_last;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic                 dat_req, grant_isa;
    logic                 unused_rd_bits;

    ddr_burst_arbiter_beat_counter #(.WIDTH(LEN_WIDTH)) u_burst_beat_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (cnt_en),
        .len   (len_q),
        .count (cnt_q),
        .last  (cnt_last)
    );

    assign dat_req         = dat_rd_req || dat_wr_req;
    assign grant_isa       = isa_rd_req && (!dat_req || (last_grant_q == GRANT_DATA));
    assign dat_wr_data_req = (state_q == ST_DAT_WR) && wr_burst_data_req;
    assign wr_burst_data   = (state_q == ST_DAT_WR) ? DDR_DATA_WIDTH'(dat_wr_data) : '0;
    assign grant_state     = state_q;
    assign unused_rd_bits  = ^rd_burst_data[DDR_DATA_WIDTH-1:ISA_WIDTH];

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        cur_isa_d       = cur_isa_q;
        started_d       = started_q;
        addr_d          = addr_q;
        len_d           = len_q;
        cnt_clear       = 1'b0;
        cnt_en          = 1'b0;
        rd_burst_req_d  = 1'b0;
        wr_burst_req_d  = 1'b0;
        rd_burst_addr_d = rd_burst_addr;
        rd_burst_len_d  = rd_burst_len;
        wr_burst_addr_d = wr_burst_addr;
        wr_burst_len_d  = wr_burst_len;
        isa_rd_data_d   = isa_rd_data;
        dat_rd_data_d   = dat_rd_data;
        isa_rd_valid_d  = 1'b0;
        dat_rd_valid_d  = 1'b0;
        isa_rd_cnt_d    = isa_rd_cnt;
        dat_rd_cnt_d    = dat_rd_cnt;
        isa_done_d      = 1'b0;
        dat_done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (isa_rd_req || dat_req) begin
                    cnt_clear = 1'b1;
                    started_d = 1'b0;
                    cur_isa_d = grant_isa;
                    if (grant_isa) begin
                        addr_d       = isa_rd_addr;
                        len_d        = isa_rd_len;
                        isa_rd_cnt_d = '0;
                        state_d      = ST_ISA_RD;
                    end else begin
                        addr_d       = dat_addr;
                        len_d        = dat_len;
                        dat_rd_cnt_d = '0;
                        state_d      = dat_wr_req ? ST_DAT_WR : ST_DAT_RD;
                    end
                    // A zero-length request never touches DDR.
                    if (len_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISA_RD, ST_DAT_RD: begin
                rd_burst_addr_d = addr_q;
                rd_burst_len_d  = len_q;
                rd_burst_req_d  = !started_q && !rd_burst_data_valid && !rd_burst_finish;
                if (rd_burst_data_valid) begin
                    started_d = 1'b1;
                    cnt_en    = 1'b1;
                    if (state_q == ST_ISA_RD) begin
                        isa_rd_valid_d = 1'b1;
                        isa_rd_data_d  = rd_burst_data[ISA_WIDTH-1:0];
                        isa_rd_cnt_d   = cnt_q + LEN_WIDTH'(1);
                    end else begin
                        dat_rd_valid_d = 1'b1;
                        dat_rd_data_d  = rd_burst_data[DATA_WIDTH-1:0];
                        dat_rd_cnt_d   = cnt_q + LEN_WIDTH'(1);
                    end
                end
                if (rd_burst_finish || cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DAT_WR: begin
                wr_burst_addr_d = addr_q;
                wr_burst_len_d  = len_q;
                wr_burst_req_d  = !started_q && !wr_burst_data_req && !wr_burst_finish;
                if (wr_burst_data_req) begin
                    started_d = 1'b1;
                    cnt_en    = 1'b1;
                end
                if (wr_burst_finish || cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cur_isa_q) begin
                    isa_done_d   = 1'b1;
                    last_grant_d = GRANT_ISA;
                end else begin
                    dat_done_d   = 1'b1;
                    last_grant_d = GRANT_DATA;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GRANT_DATA;
            cur_isa_q     <= 1'b0;
            started_q     <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            rd_burst_req  <= 1'b0;
            wr_burst_req  <= 1'b0;
            rd_burst_addr <= '0;
            rd_burst_len  <= '0;
            wr_burst_addr <= '0;
            wr_burst_len  <= '0;
            isa_rd_data   <= '0;
            dat_rd_data   <= '0;
            isa_rd_valid  <= 1'b0;
            dat_rd_valid  <= 1'b0;
            isa_rd_cnt    <= '0;
            dat_rd_cnt    <= '0;
            isa_done      <= 1'b0;
            dat_done      <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cur_isa_q     <= cur_isa_d;
            started_q     <= started_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            rd_burst_req  <= rd_burst_req_d;
            wr_burst_req  <= wr_burst_req_d;
            rd_burst_addr <= rd_burst_addr_d;
            rd_burst_len  <= rd_burst_len_d;
            wr_burst_addr <= wr_burst_addr_d;
            wr_burst_len  <= wr_burst_len_d;
            isa_rd_data   <= isa_rd_data_d;
            dat_rd_data   <= dat_rd_data_d;
            isa_rd_valid  <= isa_rd_valid_d;
            dat_rd_valid  <= dat_rd_valid_d;
            isa_rd_cnt    <= isa_rd_cnt_d;
            dat_rd_cnt    <= dat_rd_cnt_d;
            isa_done      <= isa_done_d;
            dat_done      <= dat_done_d;
        end
    end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter: the bench plays both caches and the DDR side,
// with expected words, counts and grant order computed by hand from the burst addresses.
module tb_ddr_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        isa_rd_req;
    logic [27:0] isa_rd_addr;
    logic [9:0]  isa_rd_len;
    logic [29:0] isa_rd_data;
    logic        isa_rd_valid;
    logic [9:0]  isa_rd_cnt;
    logic        isa_done;
    logic        dat_rd_req;
    logic        dat_wr_req;
    logic [27:0] dat_addr;
    logic [9:0]  dat_len;
    logic [15:0] dat_wr_data;
    logic        dat_wr_data_req;
    logic [15:0] dat_rd_data;
    logic        dat_rd_valid;
    logic [9:0]  dat_rd_cnt;
    logic        dat_done;
    logic        rd_burst_req;
    logic [27:0] rd_burst_addr;
    logic [9:0]  rd_burst_len;
    logic [63:0] rd_burst_data;
    logic        rd_burst_data_valid;
    logic        rd_burst_finish;
    logic        wr_burst_req;
    logic [27:0] wr_burst_addr;
    logic [9:0]  wr_burst_len;
    logic [63:0] wr_burst_data;
    logic        wr_burst_data_req;
    logic        wr_burst_finish;
    logic [2:0]  grant_state;

    logic [215:0] all_out;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign all_out = {rd_burst_req, wr_burst_req, rd_burst_addr, rd_burst_len, wr_burst_addr,
                      wr_burst_len, wr_burst_data, isa_rd_data, isa_rd_valid, isa_rd_cnt, isa_done,
                      dat_rd_data, dat_rd_valid, dat_rd_cnt, dat_done, dat_wr_data_req, grant_state};

    ddr_burst_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .isa_rd_req          (isa_rd_req),
        .isa_rd_addr         (isa_rd_addr),
        .isa_rd_len          (isa_rd_len),
        .isa_rd_data         (isa_rd_data),
        .isa_rd_valid        (isa_rd_valid),
        .isa_rd_cnt          (isa_rd_cnt),
        .isa_done            (isa_done),
        .dat_rd_req          (dat_rd_req),
        .dat_wr_req          (dat_wr_req),
        .dat_addr            (dat_addr),
        .dat_len             (dat_len),
        .dat_wr_data         (dat_wr_data),
        .dat_wr_data_req     (dat_wr_data_req),
        .dat_rd_data         (dat_rd_data),
        .dat_rd_valid        (dat_rd_valid),
        .dat_rd_cnt          (dat_rd_cnt),
        .dat_done            (dat_done),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_finish     (wr_burst_finish),
        .grant_state         (grant_state)
    );

    // DDR beat content: junk in the upper bits so truncation to 30/16 bits is visible.
    function automatic logic [63:0] beat_pattern(input logic [27:0] x);
        return {16'hFACE, 18'h0, 2'b00, x};
    endfunction

    // Plays the DDR read side for one burst and checks what the arbiter forwards.
    task automatic serve_read(input logic is_isa, input logic [27:0] addr, input logic [9:0] len,
                              input int lat, input logic keep_req);
        int cyc;
        logic [27:0] exp_word;
        logic [1:0]  exp_done;
        cyc = 0;
        while (rd_burst_req !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (rd_burst_req !== 1'b1) begin
            fails++;
            $display("FAIL rd_req_timeout: rd_burst_req=%b, want 1", rd_burst_req);
            return;
        end
        tests++;
        if (grant_state !== (is_isa ? 3'd1 : 3'd2) || rd_burst_addr !== addr || rd_burst_len !== len) begin
            fails++;
            $display("FAIL rd_grant: state=%0d addr=%h len=%0d, want state=%0d addr=%h len=%0d",
                     grant_state, rd_burst_addr, rd_burst_len, is_isa ? 1 : 2, addr, len);
        end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            tests++;
            if (rd_burst_req !== 1'b1) begin
                fails++;
                $display("FAIL rd_req_hold: rd_burst_req=%b, want 1", rd_burst_req);
            end
        end
        for (int k = 0; k < int'(len); k++) begin
            rd_burst_data_valid = 1'b1;
            rd_burst_data       = beat_pattern(addr + 28'(k));
            rd_burst_finish     = (k == int'(len) - 1);
            @(negedge clk);
            rd_burst_data_valid = 1'b0;
            rd_burst_finish     = 1'b0;
            exp_word = addr + 28'(k);
            tests++;
            if (is_isa) begin
                if (isa_rd_valid !== 1'b1 || isa_rd_data !== {2'b00, exp_word} ||
                    isa_rd_cnt !== 10'(k + 1) || dat_rd_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL isa_beat %0d: valid=%b data=%h cnt=%0d dat_valid=%b, want 1 %h %0d 0",
                             k, isa_rd_valid, isa_rd_data, isa_rd_cnt, dat_rd_valid, {2'b00, exp_word}, k + 1);
                end
            end else begin
                if (dat_rd_valid !== 1'b1 || dat_rd_data !== exp_word[15:0] ||
                    dat_rd_cnt !== 10'(k + 1) || isa_rd_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL dat_beat %0d: valid=%b data=%h cnt=%0d isa_valid=%b, want 1 %h %0d 0",
                             k, dat_rd_valid, dat_rd_data, dat_rd_cnt, isa_rd_valid, exp_word[15:0], k + 1);
                end
            end
            tests++;
            if (rd_burst_req !== 1'b0) begin
                fails++;
                $display("FAIL rd_req_drop: rd_burst_req=%b, want 0", rd_burst_req);
            end
        end
        @(negedge clk);
        exp_done = is_isa ? 2'b10 : 2'b01;
        tests++;
        if ({isa_done, dat_done} !== exp_done) begin
            fails++;
            $display("FAIL done_pulse: isa_done,dat_done=%b, want %b", {isa_done, dat_done}, exp_done);
        end
        if (!keep_req) begin
            if (is_isa) isa_rd_req = 1'b0;
            else        dat_rd_req = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (isa_done !== 1'b0 || dat_done !== 1'b0 || (is_isa ? isa_rd_cnt : dat_rd_cnt) !== len) begin
            fails++;
            $display("FAIL done_after: isa_done=%b dat_done=%b cnt=%0d, want 0 0 %0d",
                     isa_done, dat_done, is_isa ? isa_rd_cnt : dat_rd_cnt, len);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        isa_rd_req = 1'b0; isa_rd_addr = '0; isa_rd_len = '0;
        dat_rd_req = 1'b0; dat_wr_req = 1'b0; dat_addr = '0; dat_len = '0; dat_wr_data = '0;
        rd_burst_data = '0; rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
        wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
        @(negedge clk);
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL reset_outputs: %h, want 0", all_out);
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (grant_state !== 3'd0 || rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: state=%0d rd_req=%b wr_req=%b, want 0 0 0",
                     grant_state, rd_burst_req, wr_burst_req);
        end
    endtask

    task automatic test_isa_only();
        isa_rd_addr = 28'h000_0000;
        isa_rd_len  = 10'd128;
        isa_rd_req  = 1'b1;
        serve_read(1'b1, 28'h000_0000, 10'd128, 2, 1'b0);
    endtask

    task automatic test_stray_beats();
        rd_burst_data       = beat_pattern(28'h0ABCDEF);
        rd_burst_data_valid = 1'b1;
        rd_burst_finish     = 1'b1;
        wr_burst_data_req   = 1'b1;
        wr_burst_finish     = 1'b1;
        dat_wr_data         = 16'hBEEF;
        #1;
        tests++;
        if (dat_wr_data_req !== 1'b0 || wr_burst_data !== 64'h0) begin
            fails++;
            $display("FAIL stray_wr: dat_wr_data_req=%b wr_burst_data=%h, want 0 0", dat_wr_data_req, wr_burst_data);
        end
        @(negedge clk);
        rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
        wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0; dat_wr_data = '0;
        tests++;
        if (isa_rd_valid !== 1'b0 || dat_rd_valid !== 1'b0 || grant_state !== 3'd0 || isa_rd_cnt !== 10'd128) begin
            fails++;
            $display("FAIL stray_rd: isa_valid=%b dat_valid=%b state=%0d isa_cnt=%0d, want 0 0 0 128",
                     isa_rd_valid, dat_rd_valid, grant_state, isa_rd_cnt);
        end
    endtask

    task automatic test_same_cycle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        isa_rd_addr = 28'h000_0800; isa_rd_len = 10'd4;
        dat_addr    = 28'h003_00F0; dat_len    = 10'd3;
        isa_rd_req  = 1'b1;
        dat_rd_req  = 1'b1;
        serve_read(1'b1, 28'h000_0800, 10'd4, 1, 1'b0);
        serve_read(1'b0, 28'h003_00F0, 10'd3, 2, 1'b0);
    endtask

    task automatic test_round_robin();
        isa_rd_addr = 28'h000_0400; isa_rd_len = 10'd3;
        dat_addr    = 28'h005_1230; dat_len    = 10'd2;
        isa_rd_req  = 1'b1;
        dat_rd_req  = 1'b1;
        serve_read(1'b1, 28'h000_0400, 10'd3, 1, 1'b1);
        serve_read(1'b0, 28'h005_1230, 10'd2, 0, 1'b0);
        serve_read(1'b1, 28'h000_0400, 10'd3, 0, 1'b0);
    endtask

    task automatic test_data_write();
        logic [15:0] words [4];
        int cyc;
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        dat_addr   = 28'h000_0100;
        dat_len    = 10'd4;
        dat_wr_req = 1'b1;
        dat_rd_req = 1'b1;
        cyc = 0;
        while (wr_burst_req !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (wr_burst_req !== 1'b1 || grant_state !== 3'd3 || wr_burst_addr !== 28'h000_0100 ||
            wr_burst_len !== 10'd4 || rd_burst_req !== 1'b0) begin
            fails++;
            $display("FAIL wr_grant: wr_req=%b state=%0d addr=%h len=%0d rd_req=%b, want 1 3 0000100 4 0",
                     wr_burst_req, grant_state, wr_burst_addr, wr_burst_len, rd_burst_req);
        end
        @(negedge clk);
        tests++;
        if (wr_burst_req !== 1'b1) begin
            fails++;
            $display("FAIL wr_req_hold: wr_burst_req=%b, want 1", wr_burst_req);
        end
        for (int k = 0; k < 4; k++) begin
            wr_burst_data_req = 1'b1;
            wr_burst_finish   = (k == 3);
            #1;
            tests++;
            if (dat_wr_data_req !== 1'b1) begin
                fails++;
                $display("FAIL wr_data_req %0d: dat_wr_data_req=%b, want 1", k, dat_wr_data_req);
            end
            dat_wr_data = words[k];
            #1;
            tests++;
            if (wr_burst_data !== {48'h0, words[k]}) begin
                fails++;
                $display("FAIL wr_beat %0d: wr_burst_data=%h, want %h", k, wr_burst_data, {48'h0, words[k]});
            end
            @(negedge clk);
            wr_burst_data_req = 1'b0;
            wr_burst_finish   = 1'b0;
            tests++;
            if (wr_burst_req !== 1'b0) begin
                fails++;
                $display("FAIL wr_req_drop: wr_burst_req=%b, want 0", wr_burst_req);
            end
        end
        @(negedge clk);
        tests++;
        if (dat_done !== 1'b1 || isa_done !== 1'b0) begin
            fails++;
            $display("FAIL wr_done: dat_done=%b isa_done=%b, want 1 0", dat_done, isa_done);
        end
        dat_wr_req = 1'b0;
        @(negedge clk);
        tests++;
        if (dat_done !== 1'b0) begin
            fails++;
            $display("FAIL wr_done_width: dat_done=%b, want 0", dat_done);
        end
        serve_read(1'b0, 28'h000_0100, 10'd4, 0, 1'b0);
    endtask

    task automatic test_len_zero();
        dat_addr   = 28'h000_0200;
        dat_len    = 10'd0;
        dat_rd_req = 1'b1;
        @(negedge clk);
        tests++;
        if (dat_done !== 1'b0 || rd_burst_req !== 1'b0 || grant_state !== 3'd4) begin
            fails++;
            $display("FAIL len0_first: done=%b rd_req=%b state=%0d, want 0 0 4", dat_done, rd_burst_req, grant_state);
        end
        @(negedge clk);
        tests++;
        if (dat_done !== 1'b1 || rd_burst_req !== 1'b0) begin
            fails++;
            $display("FAIL len0_done: done=%b rd_req=%b, want 1 0", dat_done, rd_burst_req);
        end
        dat_rd_req = 1'b0;
        @(negedge clk);
        tests++;
        if (dat_done !== 1'b0 || rd_burst_req !== 1'b0 || dat_rd_cnt !== 10'd0 || grant_state !== 3'd0) begin
            fails++;
            $display("FAIL len0_after: done=%b rd_req=%b cnt=%0d state=%0d, want 0 0 0 0",
                     dat_done, rd_burst_req, dat_rd_cnt, grant_state);
        end
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        isa_rd_addr = 28'h000_0200;
        isa_rd_len  = 10'd8;
        isa_rd_req  = 1'b1;
        cyc = 0;
        while (rd_burst_req !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (rd_burst_req !== 1'b1) begin
            fails++;
            $display("FAIL midrst_req_timeout: rd_burst_req=%b, want 1", rd_burst_req);
        end
        for (int k = 0; k < 3; k++) begin
            rd_burst_data_valid = 1'b1;
            rd_burst_data       = beat_pattern(28'h000_0200 + 28'(k));
            @(negedge clk);
            rd_burst_data_valid = 1'b0;
        end
        tests++;
        if (isa_rd_cnt !== 10'd3) begin
            fails++;
            $display("FAIL midrst_cnt: isa_rd_cnt=%0d, want 3", isa_rd_cnt);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: %h, want 0", all_out);
        end
        isa_rd_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (isa_done !== 1'b0) begin
                fails++;
                $display("FAIL midrst_no_done: isa_done=%b, want 0", isa_done);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        isa_rd_addr = 28'h000_0300;
        isa_rd_len  = 10'd4;
        isa_rd_req  = 1'b1;
        serve_read(1'b1, 28'h000_0300, 10'd4, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_isa_only();
        test_stray_beats();
        test_same_cycle();
        test_round_robin();
        test_data_write();
        test_len_zero();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
